// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready byte input, DEPTH-entry FIFO, LSB-first 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (11-bit frame).
module uart_tx_stream #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx_serial,
    output logic                   busy,
    output logic                   tx_done,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [AddrW:0]  Full    = (AddrW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    logic [7:0]       mem [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             push, pop;

    // Ready comes only from registered occupancy, so a full FIFO refuses even on a pop cycle.
    assign in_ready   = (count_q != Full);
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;
    assign busy       = (state_q != StIdle);
    assign tx_serial  = tx_q;
    assign bit_end    = (cnt_q == BitLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            if (push && !pop) begin
                count_q <= count_q + (AddrW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AddrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx_done   = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) begin
                    tx_done = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = ^shift_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: directed scenarios plus randomized traffic against
// a frame-timeline reference model. Honours UART_TX_PARITY_EN for the 11-bit frame.
module tb_uart_tx_stream;
    localparam int unsigned C     = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * C;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [7:0]             in_data = 8'h00;
    logic                   in_valid = 1'b0;
    logic                   in_ready, tx_serial, busy, tx_done;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_tx_stream #(.CLKS_PER_BIT(C), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_serial  (tx_serial),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: queued bytes plus position within the current frame (-1 = idle line).
    logic [7:0] m_q[$];
    int         m_t = -1;
    logic [7:0] m_cur = 8'h00;

    // Recorded line samples and decoded results.
    logic       line_q[$];
    int         line_base = 0;
    int         done_q[$];
    int         peak = 0;
    logic [7:0] dec_q[$];
    logic       par_q[$];
    int         st_q[$];

    function automatic logic exp_tx();
        int b;
        if (m_t < 0) return 1'b1;
        b = m_t / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        if (b == 9 && NBITS == 11) return ^m_cur;
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_t >= 0;
    endfunction

    function automatic logic exp_done();
        return m_t == int'(FRAME) - 1;
    endfunction

    function automatic logic exp_ready();
        return m_q.size() != DEPTH;
    endfunction

    task automatic tick();
        int sz;
        logic acc;
        @(posedge clk);
        sz  = m_q.size();
        acc = in_valid && (sz != DEPTH);
        if (rst) begin
            m_q.delete();
            m_t = -1;
        end else begin
            if (m_t >= 0) begin
                m_t++;
                if (m_t == int'(FRAME)) m_t = -1;
            end else if (sz != 0) begin
                m_cur = m_q.pop_front();
                m_t   = 0;
            end
            if (acc) m_q.push_back(in_data);
        end
        cyc++;
        #1;
        line_q.push_back(tx_serial);
        if (tx_done) done_q.push_back(cyc);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
    endtask

    task automatic clear_rec();
        line_q.delete();
        done_q.delete();
        peak      = 0;
        line_base = cyc + 1;
    endtask

    // Finds start edges on the recorded line and samples each bit at its centre.
    task automatic decode();
        int i;
        logic [7:0] b;
        dec_q.delete();
        par_q.delete();
        st_q.delete();
        i = 1;
        while (i + int'(FRAME) <= line_q.size()) begin
            if (line_q[i-1] && !line_q[i]) begin
                for (int k = 0; k < 8; k++) b[k] = line_q[i + (k + 1) * C + C / 2];
                dec_q.push_back(b);
                if (NBITS == 11) par_q.push_back(line_q[i + 9 * C + C / 2]);
                st_q.push_back(line_base + i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (tx_serial !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 ||
                fifo_count !== '0 || tx_done !== 1'b0) begin
                $display("FAIL reset_idle cyc %0d: tx=%b busy=%b ready=%b count=%0d done=%b, want 1 0 1 0 0",
                         cyc, tx_serial, busy, in_ready, fifo_count, tx_done);
            end else passed++;
        end
    endtask

    task automatic test_single_frame();
        int n;
        clear_rec();
        n = cyc;
        in_data = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < int'(FRAME) + 10; i++) begin
            tick();
            checks++;
            if (tx_serial !== exp_tx() || busy !== exp_busy() || tx_done !== exp_done()) begin
                $display("FAIL single_a5 cyc %0d: tx/busy/done=%b%b%b want %b%b%b", cyc,
                         tx_serial, busy, tx_done, exp_tx(), exp_busy(), exp_done());
            end else passed++;
        end
        decode();
        checks++;
        if (dec_q.size() != 1 || dec_q[0] !== 8'hA5) begin
            $display("FAIL single_a5 data: got %0d frames first=%h, want 1 frame a5",
                     dec_q.size(), dec_q.size() > 0 ? dec_q[0] : 8'h00);
        end else passed++;
        checks++;
        if (st_q.size() != 1 || st_q[0] != n + 2) begin
            $display("FAIL single_a5 start: got cyc %0d, want %0d",
                     st_q.size() > 0 ? st_q[0] : -1, n + 2);
        end else passed++;
        checks++;
        if (done_q.size() != 1 || done_q[0] != n + 1 + int'(FRAME)) begin
            $display("FAIL single_a5 tx_done: got %0d pulses first at %0d, want 1 at %0d",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1, n + 1 + int'(FRAME));
        end else passed++;
    endtask

    task automatic test_back_to_back();
        clear_rec();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL b2b accept byte %0d: in_ready=%b, want 1", k + 1, in_ready);
            end else passed++;
            in_data = 8'(k + 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
            $display("FAIL b2b full: in_ready=%b count=%0d, want 0 4", in_ready, fifo_count);
        end else passed++;
        for (int i = 0; i < 5 * (int'(FRAME) + 1) + 10; i++) begin
            tick();
            checks++;
            if (tx_serial !== exp_tx() || tx_done !== exp_done() ||
                in_ready !== exp_ready() || int'(fifo_count) != m_q.size()) begin
                $display("FAIL b2b cyc %0d: tx=%b done=%b ready=%b count=%0d, want %b %b %b %0d",
                         cyc, tx_serial, tx_done, in_ready, fifo_count,
                         exp_tx(), exp_done(), exp_ready(), m_q.size());
            end else passed++;
        end
        decode();
        checks++;
        if (dec_q.size() != 5 || dec_q[0] !== 8'h01 || dec_q[1] !== 8'h02 ||
            dec_q[2] !== 8'h03 || dec_q[3] !== 8'h04 || dec_q[4] !== 8'h05) begin
            $display("FAIL b2b order: got %0d frames %p, want 01..05", dec_q.size(), dec_q);
        end else passed++;
        checks++;
        if (done_q.size() != 5) begin
            $display("FAIL b2b tx_done count: got %0d, want 5", done_q.size());
        end else passed++;
        for (int k = 1; k < done_q.size(); k++) begin
            checks++;
            if (done_q[k] - done_q[k-1] != int'(FRAME) + 1) begin
                $display("FAIL b2b period %0d: got %0d, want %0d", k,
                         done_q[k] - done_q[k-1], FRAME + 1);
            end else passed++;
        end
        checks++;
        if (peak != 4) begin
            $display("FAIL b2b peak count: got %0d, want 4", peak);
        end else passed++;
    endtask

    task automatic test_full_hold();
        logic [7:0] seq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic accepted;
        clear_rec();
        for (int k = 0; k < 5; k++) begin
            in_data = seq[k];
            in_valid = 1'b1;
            tick();
        end
        in_data = 8'hFF;
        accepted = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL hold first full: in_ready=%b, want 0", in_ready);
        end else passed++;
        for (int i = 0; i < 2 * int'(FRAME) && !accepted; i++) begin
            checks++;
            if (in_ready !== exp_ready() || int'(fifo_count) != m_q.size()) begin
                $display("FAIL hold cyc %0d: ready=%b count=%0d, want %b %0d",
                         cyc, in_ready, fifo_count, exp_ready(), m_q.size());
            end else passed++;
            accepted = exp_ready();
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (!accepted) begin
            $display("FAIL hold timeout: 0xff never accepted, want accepted within %0d", 2 * FRAME);
        end else passed++;
        for (int i = 0; i < 6 * (int'(FRAME) + 1) + 10; i++) begin
            tick();
            checks++;
            if (tx_serial !== exp_tx() || int'(fifo_count) != m_q.size()) begin
                $display("FAIL hold drain cyc %0d: tx=%b count=%0d, want %b %0d",
                         cyc, tx_serial, fifo_count, exp_tx(), m_q.size());
            end else passed++;
        end
        decode();
        checks++;
        if (dec_q.size() != 6 || dec_q[0] !== 8'h11 || dec_q[1] !== 8'h22 || dec_q[2] !== 8'h33 ||
            dec_q[3] !== 8'h44 || dec_q[4] !== 8'h55 || dec_q[5] !== 8'hFF) begin
            $display("FAIL hold data: got %0d frames %p, want 11 22 33 44 55 ff",
                     dec_q.size(), dec_q);
        end else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic found;
        in_valid = 1'b1;
        in_data = 8'h3C;
        tick();
        in_data = 8'hA1;
        tick();
        in_data = 8'hB2;
        tick();
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2 * int'(FRAME) && !found; i++) begin
            if (m_t == 4 * int'(C) + 1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found || m_q.size() != 2 || m_cur !== 8'h3C) begin
            $display("FAIL rst_mid setup: bit3 reached=%b queued=%0d, want 1 2", found, m_q.size());
        end else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (tx_serial !== 1'b1 || busy !== 1'b0 || fifo_count !== '0 ||
            tx_done !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL rst_mid after: tx=%b busy=%b count=%0d done=%b ready=%b, want 1 0 0 0 1",
                     tx_serial, busy, fifo_count, tx_done, in_ready);
        end else passed++;
        for (int i = 0; i < 2 * int'(FRAME); i++) begin
            tick();
            checks++;
            if (tx_done !== 1'b0 || tx_serial !== 1'b1) begin
                $display("FAIL rst_mid quiet cyc %0d: done=%b tx=%b, want 0 1", cyc, tx_done, tx_serial);
            end else passed++;
        end
        clear_rec();
        in_data = 8'h55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < int'(FRAME) + 10; i++) tick();
        decode();
        checks++;
        if (dec_q.size() != 1 || dec_q[0] !== 8'h55 || done_q.size() != 1) begin
            $display("FAIL rst_mid resume: got %0d frames %p, %0d done, want 1 frame 55 1 done",
                     dec_q.size(), dec_q, done_q.size());
        end else passed++;
    endtask

    task automatic test_parity();
        logic [7:0] pb [2] = '{8'hA5, 8'h07};
        logic       pp [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            clear_rec();
            in_data = pb[k];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int i = 0; i < int'(FRAME) + 10; i++) tick();
            decode();
            checks++;
            if (dec_q.size() != 1 || dec_q[0] !== pb[k] || done_q.size() != 1 ||
                done_q[0] - st_q[0] + 1 != int'(FRAME)) begin
                $display("FAIL frame_len %h: %0d frames, length %0d, want 1 frame length %0d",
                         pb[k], dec_q.size(),
                         (done_q.size() > 0 && st_q.size() > 0) ? done_q[0] - st_q[0] + 1 : -1,
                         FRAME);
            end else passed++;
`ifdef UART_TX_PARITY_EN
            checks++;
            if (par_q.size() != 1 || par_q[0] !== pp[k]) begin
                $display("FAIL parity %h: got %b, want %b", pb[k],
                         par_q.size() > 0 ? par_q[0] : 1'bx, pp[k]);
            end else passed++;
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            in_valid = ($urandom_range(0, 2) == 0);
            in_data = 8'($urandom);
            tick();
            checks++;
            if (tx_serial !== exp_tx() || busy !== exp_busy() || tx_done !== exp_done() ||
                in_ready !== exp_ready() || int'(fifo_count) != m_q.size()) begin
                $display("FAIL random cyc %0d: tx/busy/done/ready=%b%b%b%b count=%0d, want %b%b%b%b %0d",
                         cyc, tx_serial, busy, tx_done, in_ready, fifo_count,
                         exp_tx(), exp_busy(), exp_done(), exp_ready(), m_q.size());
            end else passed++;
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_hold();
        test_reset_mid_frame();
        test_parity();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Buffered 8N1 UART transmitter with a valid/ready byte input. It is the transmit counterpart to the receive path: it accepts bytes from a producer into a small internal FIFO and serialises them LSB first on tx_serial. It sits between the FIFO/parallel-input logic and the board Tx pin, and replaces the one-shot enable pulse with a flow-controlled handshake.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud); must be >= 2.
DEPTH, 4, input FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  8  byte to transmit.
in_valid  input  1  producer has a byte on in_data.
in_ready  output  1  FIFO can accept a byte; a transfer occurs on any cycle where in_valid & in_ready.
tx_serial  output  1  serial line; idles high.
busy  output  1  a frame is being shifted out (START through STOP).
tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.
fifo_count  output  clog2(DEPTH)+1  bytes currently held in the FIFO.

Behaviour:
- Reset values: tx_serial=1, busy=0, tx_done=0, in_ready=1, fifo_count=0. The FIFO is flushed, the FSM goes to IDLE, and the baud counter and bit index are cleared.
- Reset mid-frame aborts the frame. tx_serial returns high on the next cycle and no tx_done is issued.
- FIFO: in_ready = (fifo_count != DEPTH), driven from registered state with no combinational path from in_valid. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave fifo_count unchanged. When full, in_ready=0 and any in_valid is ignored, even if a pop happens that cycle.
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx_serial=1, busy=0. If fifo_count != 0, pop the head into the shift register and go to START.
  - START: tx_serial=0 for one bit time, then go to DATA with bit index 0.
  - DATA: tx_serial = shift[bit index], bits 0..7, LSB first. After bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: see Optional Feature.
  - STOP: tx_serial=1 for one bit time. tx_done=1 on its final cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- Latency: a byte accepted in cycle N into an empty FIFO while the FSM is IDLE is popped in cycle N+1. tx_serial first goes low in cycle N+2.
- Back-to-back frames: after STOP the FSM spends exactly one IDLE cycle (tx_serial=1) before the next START. Minimum frame period is 10*CLKS_PER_BIT+1 cycles, or 11*CLKS_PER_BIT+1 with parity.
- A byte is popped only in IDLE. in_data changing during a frame does not affect that frame.
- Expected RTL size: about 150-250 lines.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for one bit time, so the frame is 11 bits.
- Undefined: the PARITY state and its logic are absent, and the frame is 10 bits (8N1).
- Ports are identical in both builds.

Test Plan:
1. Reset, then hold idle for 20 cycles -> tx_serial=1, busy=0, in_ready=1, fifo_count=0, tx_done never asserted.
2. CLKS_PER_BIT=4, push 0xA5 at cycle N -> tx_serial low from N+2 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. tx_done pulses at N+41. Total frame is 40 cycles.
3. Push 5 bytes (0x01..0x05) on consecutive cycles with DEPTH=4 -> all 5 accepted; the first is popped before the fifth arrives, fifo_count peaks at 4, and in_ready drops accordingly. Frames come out in order, separated by exactly 1 idle cycle. Five tx_done pulses in total.
4. Fill the FIFO while a frame is active, hold in_valid with 0xFF -> in_ready=0 and no push until the next pop. Verify the byte is neither dropped nor duplicated.
5. Assert rst during data bit 3 of 0x3C with 2 bytes queued -> next cycle tx_serial=1, busy=0, fifo_count=0, no tx_done. A subsequent push of 0x55 transmits normally.
6. With UART_TX_PARITY_EN, push 0xA5 -> parity bit 0 and frame of 44 cycles. Push 0x07 -> parity bit 1. Without the macro, frame length for 0x07 is 40 cycles.
